// File: rtl/pov_fetch_pkg.sv
// pov_fetch_pkg
//   Shared definitions for the POV column fetcher:
//   - fetch_state_e : fetcher FSM states (IDLE / ISSUE / DRAIN)
//   - DEF_*         : default parameter values for the fetcher
//   - entry_w/sop_pos/eop_pos : layout of one output FIFO entry,
//                     {eop, sop, data}, with data in the low DATA_W bits.
package pov_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  localparam int DEF_ADDR_W        = 13;
  localparam int DEF_DATA_W        = 32;
  localparam int DEF_WORDS_PER_COL = 8;
  localparam int DEF_NUM_COLS      = 160;
  localparam int DEF_BASE_ADDR     = 0;
  localparam int DEF_FIFO_DEPTH    = 4;
  localparam int DEF_COL_W         = 8;

  // FIFO entry = {eop, sop, data[data_w-1:0]}
  function automatic int entry_w(input int data_w);
    return data_w + 2;
  endfunction

  function automatic int sop_pos(input int data_w);
    return data_w;
  endfunction

  function automatic int eop_pos(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/pov_fetch_fifo.sv
// pov_fetch_fifo
//   Synchronous show-ahead FIFO: the oldest entry is always visible on
//   `head` while `empty` is low; `pop` consumes it at the clock edge.
//   A push into a full FIFO is accepted only when a pop happens in the
//   same cycle. All flags are registered.
// Ports:
//   clk, reset         : clock, synchronous active-high reset (clears all)
//   push, push_data    : write request and entry
//   pop                : consume head (ignored when empty)
//   head               : oldest entry
//   count, full, empty : occupancy
module pov_fetch_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_eff;
  logic             push_eff;
  logic [CNT_W-1:0] count_n;

  always_comb begin
    pop_eff  = pop & ~empty;
    push_eff = push & (~full | pop_eff);
    count_n  = count + CNT_W'(push_eff) - CNT_W'(pop_eff);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_eff) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_eff) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_n;
      empty <= (count_n == '0);
      full  <= (count_n == CNT_W'(DEPTH));
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/pov_column_fetcher.sv
// pov_column_fetcher
//   Avalon-MM read master that fetches one image column (WORDS_PER_COL
//   consecutive 32-bit words) and emits it as one Avalon-ST packet.
//   Reads are pipelined; a read is only issued while the output FIFO has
//   room for every word already in flight, so sink back-pressure can never
//   overflow returned data.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, column       : column request (accepted only while idle)
//   busy                : column in progress
//   err_range           : one-cycle pulse for an out-of-range column
//   avm_*               : Avalon-MM read master
//   src_*               : Avalon-ST source (valid/ready, sop/eop)
//   dbg_state           : current FSM state
//
// Handshakes: an Avalon-MM read transfers when avm_read=1 and
// avm_waitrequest=0 in the same cycle; address and read are held while
// waitrequest is high. A stream word transfers when src_valid=1 and
// src_ready=1 in the same cycle; src_valid, data and flags never change
// while src_valid=1 and src_ready=0.
module pov_column_fetcher
  import pov_fetch_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int WORDS_PER_COL = DEF_WORDS_PER_COL,
  parameter int NUM_COLS      = DEF_NUM_COLS,
  parameter int BASE_ADDR     = DEF_BASE_ADDR,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int COL_W         = DEF_COL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [COL_W-1:0]  column,
  output logic              busy,
  output logic              err_range,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_startofpacket,
  output logic              src_endofpacket,
  output fetch_state_e      dbg_state
);

  localparam int LOG_W   = $clog2(WORDS_PER_COL);
  localparam int IDX_W   = LOG_W + 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int BASE_W  = COL_W + LOG_W;
  localparam int ENTRY_W = entry_w(DATA_W);
  localparam int SOP_B   = sop_pos(DATA_W);
  localparam int EOP_B   = eop_pos(DATA_W);

  fetch_state_e        state, state_n;
  logic [BASE_W-1:0]   word_base, word_base_n;
  logic [IDX_W-1:0]    issue_idx, issue_idx_n;
  logic [IDX_W-1:0]    rx_idx;
  logic [CNT_W-1:0]    outstanding, outstanding_n;
  logic [CNT_W-1:0]    fifo_count, fifo_count_n;
  logic                fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]  push_entry, head_entry;
  logic                col_ok, accept_start;
  logic                issue_acc, rx_acc, pop_acc, eop_acc;
  logic                read_n;
  logic [31:0]         word_sum;
  logic [ADDR_W-1:0]   addr_n;

  always_comb begin
    col_ok       = 32'(column) < 32'(NUM_COLS);
    accept_start = (state == S_IDLE) && start && col_ok;
    issue_acc    = avm_read & ~avm_waitrequest;
    // Returned data is only meaningful while a column is in progress;
    // anything arriving while idle (e.g. after a reset) is dropped.
    rx_acc       = avm_readdatavalid & (state != S_IDLE);
    pop_acc      = src_valid & src_ready;
    eop_acc      = pop_acc & src_endofpacket;

    outstanding_n = outstanding + CNT_W'(issue_acc) - CNT_W'(rx_acc);
    fifo_count_n  = fifo_count + CNT_W'(rx_acc) - CNT_W'(pop_acc);

    state_n     = state;
    word_base_n = word_base;
    issue_idx_n = issue_idx;

    case (state)
      S_IDLE: begin
        if (accept_start) begin
          state_n     = S_ISSUE;
          word_base_n = {column, {LOG_W{1'b0}}};
          issue_idx_n = '0;
        end
      end
      S_ISSUE: begin
        if (issue_acc) begin
          issue_idx_n = issue_idx + IDX_W'(1);
          if (issue_idx == IDX_W'(WORDS_PER_COL - 1)) state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (eop_acc) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // A stalled request is held regardless of credits: while it waits,
    // FIFO + outstanding can only shrink, so its credit stays reserved.
    read_n = (state_n == S_ISSUE) &&
             ((avm_read && avm_waitrequest) ||
              ((32'(fifo_count_n) + 32'(outstanding_n)) < 32'(FIFO_DEPTH)));

    word_sum = 32'(word_base_n) + 32'(issue_idx_n);
    addr_n   = (state_n == S_ISSUE) ?
               ADDR_W'(32'(BASE_ADDR) + (word_sum << 2)) : avm_address;

    push_entry = {(rx_idx == IDX_W'(WORDS_PER_COL - 1)),
                  (rx_idx == '0),
                  avm_readdata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      word_base   <= '0;
      issue_idx   <= '0;
      rx_idx      <= '0;
      outstanding <= '0;
      busy        <= 1'b0;
      err_range   <= 1'b0;
      avm_read    <= 1'b0;
      avm_address <= ADDR_W'(BASE_ADDR);
    end else begin
      state       <= state_n;
      word_base   <= word_base_n;
      issue_idx   <= issue_idx_n;
      outstanding <= outstanding_n;
      busy        <= (state_n != S_IDLE);
      err_range   <= (state == S_IDLE) && start && !col_ok;
      avm_read    <= read_n;
      avm_address <= addr_n;
      if (accept_start)  rx_idx <= '0;
      else if (rx_acc)   rx_idx <= rx_idx + IDX_W'(1);
      // The credit rule must make an overflowing push impossible.
      assert (!(rx_acc && fifo_full && !pop_acc));
    end
  end

  pov_fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_acc),
    .push_data (push_entry),
    .pop       (src_ready),
    .head      (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign src_valid         = ~fifo_empty;
  assign src_data          = head_entry[DATA_W-1:0];
  assign src_startofpacket = head_entry[SOP_B];
  assign src_endofpacket   = head_entry[EOP_B];
  assign dbg_state         = state;

endmodule

// File: doc/pov_column_fetcher.md
# pov_column_fetcher

Avalon-MM read master that fetches one image column (a fixed run of 32-bit pixel words) from the on-chip ROM/RAM slave and presents it as an Avalon-ST packet to the LED shift driver. It sits between the column-timing logic, which issues `start` once per angular slot, and the LED serializer. Reads are pipelined and credit-limited by an internal output FIFO, so sink back-pressure never overflows returned data.

## Interface
- `ADDR_W`, 13, byte-address width of `avm_address` (1280 words × 4 B)
- `DATA_W`, 32, pixel word width
- `WORDS_PER_COL`, 8, words per column; power of two, ≥2
- `NUM_COLS`, 160, valid columns (0..NUM_COLS-1)
- `BASE_ADDR`, 0, byte address of column 0, word 0
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥2
- `COL_W`, 8, width of `column`

- `clk` in 1, single clock; one clock; reset is synchronous and active-high
- `reset` in 1, synchronous, active-high
- `start` in 1, single-cycle request; accepted only when `busy`=0
- `column` in COL_W, column index, sampled with `start`
- `busy` out 1, high from the cycle after an accepted `start` until the cycle after the last word is accepted by the sink
- `err_range` out 1, one-cycle pulse: `start` with `column` ≥ NUM_COLS
- `avm_address` out ADDR_W, byte address
- `avm_read` out 1, read request
- `avm_waitrequest` in 1, slave stall
- `avm_readdata` in DATA_W, read data
- `avm_readdatavalid` in 1, read data qualifier
- `src_data` out DATA_W, pixel word
- `src_valid` out 1, data valid
- `src_ready` in 1, sink ready
- `src_startofpacket` out 1, first word of column
- `src_endofpacket` out 1, last word of column

## Operation
- FSM: IDLE → ISSUE → DRAIN → IDLE.
- IDLE: `start`=1, `column`<NUM_COLS → latch word base = `column`·WORDS_PER_COL (shift), issue index i=0, → ISSUE. `start`=1, `column` out of range → `err_range`=1 next cycle, stay IDLE. `start` while `busy`=1 ignored, no error.
- ISSUE: `avm_address` = BASE_ADDR + ((base+i)<<2), truncated to ADDR_W. Assert `avm_read` only when `fifo_count` + `outstanding` < FIFO_DEPTH. Address and read held stable while `avm_waitrequest`=1. On `avm_read`&~`avm_waitrequest`: i++, outstanding++. After issuing word WORDS_PER_COL-1 → DRAIN.
- `avm_readdatavalid`: push {data, sop=(rx index 0), eop=(rx index WORDS_PER_COL-1)} into the FIFO; outstanding--. Issue-accept and readdatavalid in the same cycle leave outstanding unchanged.
- DRAIN: no reads; after the EOP word is accepted (`src_valid`&`src_ready`&`src_endofpacket`) → IDLE.
- `avm_readdatavalid` while IDLE is discarded, with no counter change.
- Reset mid-column: FSM IDLE, counters and FIFO cleared, partial packet abandoned; no EOP is emitted for it.
- Credit rule guarantees the FIFO never overflows; overflow is an assertion failure.

## Timing
- Reset values: `busy`, `err_range`, `avm_read`, `src_valid`, `src_startofpacket`, `src_endofpacket` = 0; `avm_address` = BASE_ADDR; `src_data` = 0.
- All outputs registered.
- `start` accepted in cycle 0 → `avm_read`=1 and `busy`=1 in cycle 1.
- With a latency-1 slave, no waitrequest and `src_ready`=1: first `avm_readdatavalid` in cycle 2, first `src_valid` in cycle 3, one word per cycle thereafter, EOP in cycle 3+WORDS_PER_COL-1, `busy`=0 the following cycle.
- `src_valid` and its data and flags hold until `src_ready`=1.
- Back-to-back: `start` in the cycle `busy` falls is accepted.

## Structure
- Package `pov_fetch_pkg`: FSM state enum (IDLE/ISSUE/DRAIN), default parameter constants, and the FIFO entry layout {eop, sop, data}.
- Sub-module `pov_fetch_fifo`: synchronous show-ahead FIFO, width DATA_W+2, depth FIFO_DEPTH, with `count`, `full` and `empty` outputs, cleared by `reset`.

## Test plan
- Column 3, latency-1 slave, `src_ready`=1 → addresses 0x060..0x07C step 4; 8 words in consecutive cycles 3..10; SOP on word 0, EOP on word 7; `busy` falls in cycle 11.
- `src_ready`=0 for 20 cycles after start → at most 4 reads issued, `avm_read` deasserts, no data lost; release gives an in-order packet.
- `avm_waitrequest` high 3 cycles on word 2 → address held at word-2 value throughout, no duplicate or skipped word.
- `column`=160 → `err_range` pulse 1 cycle, no `avm_read`, `busy` stays 0.
- `reset` in the cycle after the 5th readdatavalid → all outputs at reset values next cycle; late `avm_readdatavalid` ignored; a new `start` on column 0 yields a clean 8-word packet.
- Last column (159) with BASE_ADDR=0 → final address 0x13FC; `start` during `busy` ignored.
